// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Round-robin owner of the single RAM port shared by NREQ requesters
// (instruction/data caches of both cores). One requester is granted at a
// time; its read/write is steered to RAM combinationally and it alone sees
// req_wait drop, for exactly the cycle the RAM reports ACCESS. Locked
// multi-beat bursts keep the grant for up to MAXLOCK beats. RAM ERROR or a
// stall of TIMEOUT granted cycles aborts the grant and sets a sticky err_flag.
//
// Handshake: a requester holds req_ren/req_wen (plus addr/store) stable until
// it sees its req_wait bit low at a rising edge; that edge completes the beat.
// Dropping the request before completion abandons the grant without error.
//
// Ports:
//   CLK, nRST          clock (rising edge), asynchronous active-low reset
//   req_ren/req_wen    per-requester read / write request
//   req_lock           per-requester "keep grant after this beat"
//   req_addr/req_store packed per-requester address / write data (32 bits each)
//   req_wait           per-requester stall, low only for the completing beat
//   req_load           read data returned to the owner
//   ramREN/ramWEN/ramaddr/ramstore/ramload/ramstate  RAM port
//   grant_valid        high exactly while in GRANT (it is the FSM state)
//   grant_id           current / last owner index
//   err_flag, err_clr  sticky error flag and its clear (set wins)
module ram_port_arbiter #(
  parameter int NREQ    = 4,
  parameter int MAXLOCK = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic [NREQ-1:0]         req_ren,
  input  logic [NREQ-1:0]         req_wen,
  input  logic [NREQ-1:0]         req_lock,
  input  logic [NREQ*32-1:0]      req_addr,
  input  logic [NREQ*32-1:0]      req_store,
  output logic [NREQ-1:0]         req_wait,
  output logic [31:0]             req_load,
  output logic                    ramREN,
  output logic                    ramWEN,
  output logic [31:0]             ramaddr,
  output logic [31:0]             ramstore,
  input  logic [31:0]             ramload,
  input  logic [1:0]              ramstate,
  output logic                    grant_valid,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    err_flag,
  input  logic                    err_clr
);

  localparam int IDW = $clog2(NREQ);
  localparam int BW  = $clog2(MAXLOCK + 1);
  localparam int TW  = $clog2(TIMEOUT);

  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  typedef enum logic {S_IDLE = 1'b0, S_GRANT = 1'b1} state_e;

  state_e         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] gid_q, gid_d;
  logic [BW-1:0]  beat_q, beat_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic           err_q, err_d;

  logic [NREQ-1:0] pending;
  logic            pick_found;
  logic [IDW-1:0]  pick_id;
  logic [IDW-1:0]  next_ptr;
  logic            own_pending;
  logic            err_set;

  assign pending     = req_ren | req_wen;
  assign own_pending = pending[gid_q];
  assign next_ptr    = (gid_q == IDW'(NREQ - 1)) ? '0 : gid_q + IDW'(1);

  // First pending index at or after the round-robin pointer, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!pick_found && pending[(int'(ptr_q) + k) % NREQ]) begin
        pick_found = 1'b1;
        pick_id    = IDW'((int'(ptr_q) + k) % NREQ);
      end
    end
  end

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      gid_q   <= '0;
      beat_q  <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      beat_q  <= beat_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic. In GRANT, a completing beat takes priority over both
  // the RAM error and the stall timeout.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    beat_d  = beat_q;
    tmo_d   = tmo_q;
    err_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          state_d = S_GRANT;
          gid_d   = pick_id;
          beat_d  = '0;
          tmo_d   = '0;
        end
      end
      S_GRANT: begin
        if (ramstate == RS_ACCESS) begin
          tmo_d = '0;
          if (req_lock[gid_q] && (int'(beat_q) + 1 < MAXLOCK)) begin
            beat_d = beat_q + BW'(1);
          end else begin
            state_d = S_IDLE;
            ptr_d   = next_ptr;
            beat_d  = '0;
          end
        end else if (ramstate == RS_ERROR || (own_pending && tmo_q == TW'(TIMEOUT - 1))) begin
          err_set = 1'b1;
          state_d = S_IDLE;
          ptr_d   = next_ptr;
          beat_d  = '0;
          tmo_d   = '0;
        end else if (!own_pending) begin
          state_d = S_IDLE;
          ptr_d   = next_ptr;
          beat_d  = '0;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
  end

  // Outputs: RAM side and wait/load are combinational from state and inputs.
  always_comb begin
    grant_valid = 1'b0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    req_load    = '0;
    req_wait    = '1;
    if (state_q == S_GRANT) begin
      grant_valid     = 1'b1;
      ramaddr         = req_addr[32*int'(gid_q) +: 32];
      ramstore        = req_store[32*int'(gid_q) +: 32];
      ramWEN          = req_wen[gid_q];
      ramREN          = req_ren[gid_q] & ~req_wen[gid_q];
      req_load        = ramload;
      req_wait[gid_q] = (ramstate != RS_ACCESS);
    end
  end

  assign grant_id = gid_q;
  assign err_flag = err_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Testbench for ram_port_arbiter: directed scenarios from the test plan plus
// a randomized run checked against a transaction-level owner/pointer model.
module tb_ram_port_arbiter;

  localparam int NREQ    = 4;
  localparam int MAXLOCK = 4;
  localparam int TIMEOUT = 64;
  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

  logic              CLK, nRST;
  logic [NREQ-1:0]   req_ren, req_wen, req_lock, req_wait;
  logic [NREQ*32-1:0] req_addr, req_store;
  logic [31:0]       req_load, ramaddr, ramstore, ramload;
  logic              ramREN, ramWEN, grant_valid, err_flag, err_clr;
  logic [1:0]        ramstate;
  logic [1:0]        grant_id;

  int checks = 0;
  int errors = 0;

  ram_port_arbiter #(.NREQ(NREQ), .MAXLOCK(MAXLOCK), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .nRST(nRST),
    .req_ren(req_ren), .req_wen(req_wen), .req_lock(req_lock),
    .req_addr(req_addr), .req_store(req_store),
    .req_wait(req_wait), .req_load(req_load),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate),
    .grant_valid(grant_valid), .grant_id(grant_id),
    .err_flag(err_flag), .err_clr(err_clr)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Owner is -1 when the port is free; rr is the next index to search from.
  int m_owner, m_rr, m_beats, m_waited, m_j;
  bit m_err, m_set;

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_owner = -1; m_rr = 0; m_beats = 0; m_waited = 0; m_err = 0;
    end else begin
      m_set = 0;
      if (m_owner < 0) begin
        for (int k = 0; k < NREQ; k++) begin
          m_j = (m_rr + k) % NREQ;
          if (m_owner < 0 && (req_ren[m_j] || req_wen[m_j])) begin
            m_owner = m_j; m_beats = 0; m_waited = 0;
          end
        end
      end else begin
        if (ramstate == ACCESS) begin
          m_beats++; m_waited = 0;
          if (!(req_lock[m_owner] && m_beats < MAXLOCK)) begin
            m_rr = (m_owner + 1) % NREQ; m_owner = -1; m_beats = 0;
          end
        end else if (ramstate == ERROR) begin
          m_set = 1; m_rr = (m_owner + 1) % NREQ; m_owner = -1; m_beats = 0; m_waited = 0;
        end else if (!(req_ren[m_owner] || req_wen[m_owner])) begin
          m_rr = (m_owner + 1) % NREQ; m_owner = -1; m_beats = 0; m_waited = 0;
        end else if (m_waited + 1 >= TIMEOUT) begin
          m_set = 1; m_rr = (m_owner + 1) % NREQ; m_owner = -1; m_beats = 0; m_waited = 0;
        end else begin
          m_waited++;
        end
      end
      if (err_clr) m_err = 0;
      if (m_set) m_err = 1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    req_ren = '0; req_wen = '0; req_lock = '0;
    req_addr = '0; req_store = '0;
    ramload = '0; ramstate = FREE; err_clr = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    nRST = 1'b0;
    tick();
    tick();
    nRST = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    clear_inputs();
    ramload = 32'hA5A5_5A5A;
    nRST = 1'b0;
    tick();
    tick();
    checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL reset_gv: got %b want 0", grant_valid); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_gid: got %0d want 0", grant_id); end
    checks++; if (req_wait !== 4'hF) begin errors++; $display("FAIL reset_wait: got %b want 1111", req_wait); end
    checks++; if (req_load !== 32'h0) begin errors++; $display("FAIL reset_load: got %h want 0", req_load); end
    checks++; if ({ramREN, ramWEN} !== 2'b00) begin errors++; $display("FAIL reset_en: got %b want 00", {ramREN, ramWEN}); end
    checks++; if ({ramaddr, ramstore} !== 64'h0) begin errors++; $display("FAIL reset_bus: got %h want 0", {ramaddr, ramstore}); end
    checks++; if (err_flag !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err_flag); end
    nRST = 1'b1;
  endtask

  task automatic test_single_read();
    do_reset();
    req_ren[2] = 1'b1;
    req_addr[95:64] = 32'h0000_0040;
    ramstate = BUSY;
    ramload = 32'hDEAD_BEEF;
    #1;
    checks++; if (grant_valid !== 1'b0 || ramREN !== 1'b0) begin errors++; $display("FAIL read_same_cycle: gv=%b ren=%b want 0 0", grant_valid, ramREN); end
    tick();
    checks++; if (grant_valid !== 1'b1 || grant_id !== 2'd2) begin errors++; $display("FAIL read_grant: gv=%b gid=%0d want 1 2", grant_valid, grant_id); end
    checks++; if (ramREN !== 1'b1 || ramWEN !== 1'b0 || ramaddr !== 32'h40) begin errors++; $display("FAIL read_ram: ren=%b wen=%b addr=%h want 1 0 40", ramREN, ramWEN, ramaddr); end
    for (int c = 0; c < 3; c++) begin
      if (c > 0) tick();
      checks++; if (req_wait !== 4'hF) begin errors++; $display("FAIL read_busy%0d: got %b want 1111", c, req_wait); end
    end
    tick();
    ramstate = ACCESS;
    #1;
    checks++; if (req_wait !== 4'b1011) begin errors++; $display("FAIL read_access_wait: got %b want 1011", req_wait); end
    checks++; if (req_load !== 32'hDEAD_BEEF) begin errors++; $display("FAIL read_load: got %h want deadbeef", req_load); end
    tick();
    req_ren = 4'b1001;
    ramstate = FREE;
    #1;
    checks++; if (grant_valid !== 1'b0 || req_wait !== 4'hF) begin errors++; $display("FAIL read_release: gv=%b wait=%b want 0 1111", grant_valid, req_wait); end
    tick();
    checks++; if (grant_id !== 2'd3) begin errors++; $display("FAIL read_ptr: gid=%0d want 3", grant_id); end
    ramstate = ACCESS;
    tick();
    clear_inputs();
  endtask

  task automatic test_round_robin();
    logic [3:0] ew;
    int n;
    do_reset();
    req_ren = 4'hF;
    ramstate = ACCESS;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (!grant_valid && n < 4) begin tick(); n++; end
      ew = 4'hF;
      ew[k % NREQ] = 1'b0;
      checks++; if (grant_valid !== 1'b1 || grant_id !== 2'(k % NREQ)) begin errors++; $display("FAIL rr_order%0d: gv=%b gid=%0d want 1 %0d", k, grant_valid, grant_id, k % NREQ); end
      checks++; if (req_wait !== ew) begin errors++; $display("FAIL rr_wait%0d: got %b want %b", k, req_wait, ew); end
      tick();
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_locked_burst();
    for (int variant = 0; variant < 2; variant++) begin
      do_reset();
      req_wen[1] = 1'b1;
      req_lock[1] = 1'b1;
      req_store[63:32] = $urandom();
      ramstate = ACCESS;
      tick();
      req_ren[0] = 1'b1;
      for (int b = 0; b < (variant == 0 ? 4 : 2); b++) begin
        if (variant == 1 && b == 1) req_lock[1] = 1'b0;
        #1;
        checks++; if (grant_valid !== 1'b1 || grant_id !== 2'd1 || req_wait !== 4'b1101) begin errors++; $display("FAIL lock_v%0d_beat%0d: gv=%b gid=%0d wait=%b want 1 1 1101", variant, b, grant_valid, grant_id, req_wait); end
        checks++; if (ramWEN !== 1'b1 || ramstore !== req_store[63:32]) begin errors++; $display("FAIL lock_v%0d_data%0d: wen=%b store=%h want 1 %h", variant, b, ramWEN, ramstore, req_store[63:32]); end
        tick();
      end
      checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL lock_v%0d_release: gv=%b want 0", variant, grant_valid); end
      tick();
      checks++; if (grant_valid !== 1'b1 || grant_id !== 2'd0) begin errors++; $display("FAIL lock_v%0d_next: gv=%b gid=%0d want 1 0", variant, grant_valid, grant_id); end
      clear_inputs();
      tick();
    end
  endtask

  task automatic test_collision();
    logic [31:0] s;
    do_reset();
    req_ren[3] = 1'b1;
    req_wen[3] = 1'b1;
    req_store[127:96] = $urandom();
    req_addr[127:96] = $urandom();
    ramstate = BUSY;
    tick();
    checks++; if (ramWEN !== 1'b1 || ramREN !== 1'b0) begin errors++; $display("FAIL coll_en: wen=%b ren=%b want 1 0", ramWEN, ramREN); end
    checks++; if (ramstore !== req_store[127:96] || ramaddr !== req_addr[127:96]) begin errors++; $display("FAIL coll_bus: store=%h addr=%h want %h %h", ramstore, ramaddr, req_store[127:96], req_addr[127:96]); end
    s = $urandom();
    req_store[127:96] = s;
    #1;
    checks++; if (ramstore !== s) begin errors++; $display("FAIL coll_live_store: got %h want %h", ramstore, s); end
    ramstate = ACCESS;
    tick();
    clear_inputs();
  endtask

  task automatic test_timeout_error();
    int n;
    bit saw;
    do_reset();
    req_ren = 4'b0011;
    ramstate = BUSY;
    tick();
    n = 0;
    saw = 0;
    while (grant_valid && n < 100) begin
      if (!req_wait[0]) saw = 1;
      n++;
      tick();
    end
    checks++; if (n != TIMEOUT) begin errors++; $display("FAIL tmo_cycles: got %0d want %0d", n, TIMEOUT); end
    checks++; if (saw) begin errors++; $display("FAIL tmo_wait: req_wait[0] dropped, want never"); end
    checks++; if (err_flag !== 1'b1) begin errors++; $display("FAIL tmo_err: got %b want 1", err_flag); end
    err_clr = 1'b1;
    ramstate = ERROR;
    tick();
    err_clr = 1'b0;
    #1;
    checks++; if (grant_valid !== 1'b1 || grant_id !== 2'd1) begin errors++; $display("FAIL tmo_ptr: gv=%b gid=%0d want 1 1", grant_valid, grant_id); end
    checks++; if (err_flag !== 1'b0 || req_wait !== 4'hF) begin errors++; $display("FAIL err_clear: err=%b wait=%b want 0 1111", err_flag, req_wait); end
    tick();
    checks++; if (grant_valid !== 1'b0 || err_flag !== 1'b1) begin errors++; $display("FAIL error_abort: gv=%b err=%b want 0 1", grant_valid, err_flag); end
    tick();
    err_clr = 1'b1;
    #1;
    checks++; if (grant_valid !== 1'b1 || grant_id !== 2'd0) begin errors++; $display("FAIL error_ptr: gv=%b gid=%0d want 1 0", grant_valid, grant_id); end
    tick();
    checks++; if (err_flag !== 1'b1) begin errors++; $display("FAIL err_set_wins: got %b want 1", err_flag); end
    req_ren = '0;
    ramstate = FREE;
    tick();
    checks++; if (err_flag !== 1'b0) begin errors++; $display("FAIL err_clr_idle: got %b want 0", err_flag); end
    clear_inputs();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    req_wen[2] = 1'b1;
    req_lock[2] = 1'b1;
    ramstate = ACCESS;
    tick();
    tick();
    req_ren = 4'b1010;
    #1;
    checks++; if (ramWEN !== 1'b1 || grant_id !== 2'd2) begin errors++; $display("FAIL mid_setup: wen=%b gid=%0d want 1 2", ramWEN, grant_id); end
    #2;
    nRST = 1'b0;
    #1;
    checks++; if ({ramREN, ramWEN} !== 2'b00 || req_wait !== 4'hF || grant_valid !== 1'b0) begin errors++; $display("FAIL mid_async: en=%b wait=%b gv=%b want 00 1111 0", {ramREN, ramWEN}, req_wait, grant_valid); end
    tick();
    tick();
    nRST = 1'b1;
    tick();
    checks++; if (grant_valid !== 1'b1 || grant_id !== 2'd1) begin errors++; $display("FAIL mid_regrant: gv=%b gid=%0d want 1 1", grant_valid, grant_id); end
    clear_inputs();
  endtask

  task automatic test_random();
    logic [NREQ-1:0] ew;
    logic e_ren, e_wen;
    logic [31:0] e_addr, e_store;
    int r;
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      req_ren  = 4'($urandom_range(0, 15));
      req_wen  = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      req_lock = 4'($urandom_range(0, 15));
      req_addr = {$urandom(), $urandom(), $urandom(), $urandom()};
      req_store = {$urandom(), $urandom(), $urandom(), $urandom()};
      ramload = $urandom();
      r = $urandom_range(0, 99);
      ramstate = (r < 40) ? ACCESS : (r < 80) ? BUSY : (r < 85) ? ERROR : FREE;
      err_clr = ($urandom_range(0, 9) == 0);
      #1;
      ew = '1; e_ren = 0; e_wen = 0; e_addr = '0; e_store = '0;
      if (m_owner >= 0) begin
        e_wen = req_wen[m_owner];
        e_ren = req_ren[m_owner] && !req_wen[m_owner];
        e_addr = req_addr[32*m_owner +: 32];
        e_store = req_store[32*m_owner +: 32];
        if (ramstate == ACCESS) ew[m_owner] = 1'b0;
      end
      checks++; if (grant_valid !== (m_owner >= 0)) begin errors++; $display("FAIL rnd_gv@%0d: got %b want %b", cyc, grant_valid, m_owner >= 0); end
      if (m_owner >= 0) begin
        checks++; if (grant_id !== 2'(m_owner)) begin errors++; $display("FAIL rnd_gid@%0d: got %0d want %0d", cyc, grant_id, m_owner); end
        checks++; if (req_load !== ramload) begin errors++; $display("FAIL rnd_load@%0d: got %h want %h", cyc, req_load, ramload); end
      end
      checks++; if ({ramREN, ramWEN} !== {e_ren, e_wen}) begin errors++; $display("FAIL rnd_en@%0d: got %b want %b", cyc, {ramREN, ramWEN}, {e_ren, e_wen}); end
      checks++; if (ramaddr !== e_addr || ramstore !== e_store) begin errors++; $display("FAIL rnd_bus@%0d: got %h %h want %h %h", cyc, ramaddr, ramstore, e_addr, e_store); end
      checks++; if (req_wait !== ew) begin errors++; $display("FAIL rnd_wait@%0d: got %b want %b", cyc, req_wait, ew); end
      checks++; if (err_flag !== m_err) begin errors++; $display("FAIL rnd_err@%0d: got %b want %b", cyc, err_flag, m_err); end
      tick();
    end
    clear_inputs();
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    nRST = 1'b0;
    clear_inputs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_locked_burst();
    test_collision();
    test_timeout_error();
    test_reset_mid_burst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
